uart_core_param: RTL and testbench

Parametrised full-duplex UART that succeeds the fixed 8N1 transmitter/receiver.
- Configurable data width, parity and stop bits.
- 16x-oversampled receiver with start-bit validation, parity and framing error detection.
- Transmit side uses a valid/ready handshake.
- Sits between on-chip logic and the serial pins; one instance per serial channel.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tick_gen.sv | 27 ++
 rtl/uart_core_param.sv | 202 ++++++++++++++++++++
 tb/tb_uart_core_param.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM encoding and parity helper
// for the parametrised UART core.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  localparam int MAX_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  // Zero-extended words do not change the reduction result.
  function automatic logic par_bit(
    input logic [MAX_BITS-1:0] w,
    input int                  mode
  );
    return (mode == PAR_ODD) ? ~^w : ^w;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: free-running divider, one-cycle tick every
// DIV clocks.
module uart_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_core_param.sv
// uart_core_param: full-duplex UART, configurable width,
// parity and stop bits, 16x-oversampled receiver.
module uart_core_param #(
  parameter int CLK_HZ     = 1_600_000,
  parameter int BAUD       = 10_000,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);
  import uart_pkg::*;

  localparam int DIV      = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int BIT_CLKS = DIV * OVERSAMPLE;
  localparam int CW       = $clog2(BIT_CLKS);
  localparam int OW       = $clog2(OVERSAMPLE);
  localparam int HALF     = OVERSAMPLE / 2;

  generate
    if (DIV < 1) begin : g_bad_div
      $error("uart_core_param: CLK_HZ below BAUD*OVERSAMPLE");
    end
  endgenerate

  logic tick;

  uart_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // TX times bits in clocks from the acceptance edge, so a
  // frame is exact regardless of the shared tick phase.
  uart_state_t          tx_state, tx_next;
  logic [CW-1:0]        tx_cnt;
  logic [3:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par;
  logic                 tx_bit_end;
  logic                 tx_hs;

  assign tx_ready   = rst_n && (tx_state == ST_IDLE);
  assign tx_hs      = tx_valid && tx_ready;
  assign tx_bit_end = (tx_cnt == CW'(BIT_CLKS - 1));

  always_comb begin
    tx_next = tx_state;
    tx_done = 1'b0;
    tx      = 1'b1;
    unique case (tx_state)
      ST_IDLE: begin
        if (tx_hs) tx_next = ST_START;
      end
      ST_START: begin
        tx = 1'b0;
        if (tx_bit_end) tx_next = ST_DATA;
      end
      ST_DATA: begin
        tx = tx_sh[0];
        if (tx_bit_end && tx_bit == 4'(DATA_BITS - 1))
          tx_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        tx = tx_par;
        if (tx_bit_end) tx_next = ST_STOP;
      end
      ST_STOP: begin
        if (tx_bit_end && tx_bit == 4'(STOP_BITS - 1)) begin
          tx_next = ST_IDLE;
          tx_done = rst_n;
        end
      end
      default: tx_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_hs) begin
        tx_cnt <= '0;
        tx_bit <= '0;
        tx_sh  <= tx_data;
        tx_par <= par_bit(MAX_BITS'(tx_data), PARITY);
      end else if (tx_state != ST_IDLE) begin
        tx_cnt <= tx_bit_end ? '0 : tx_cnt + CW'(1);
        if (tx_bit_end) begin
          tx_bit <= (tx_next != tx_state) ? '0 : tx_bit + 4'd1;
          if (tx_state == ST_DATA) tx_sh <= tx_sh >> 1;
        end
      end
    end
  end

  uart_state_t          rx_state, rx_next;
  logic                 rx_s1, rx_s2, rx_prev;
  logic [OW-1:0]        rx_os;
  logic [3:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_pe, rx_fe;
  logic                 rx_samp;
  logic                 rx_fire;

  // Mid-start sample at half a bit, then every full bit.
  assign rx_samp = tick && ((rx_state == ST_START)
                 ? (rx_os == OW'(HALF - 1))
                 : (rx_os == OW'(OVERSAMPLE - 1)));

  always_comb begin
    rx_next = rx_state;
    rx_fire = 1'b0;
    unique case (rx_state)
      ST_IDLE: begin
        if (rx_prev && !rx_s2) rx_next = ST_START;
      end
      ST_START: begin
        if (rx_samp) rx_next = rx_s2 ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (rx_samp && rx_bit == 4'(DATA_BITS - 1))
          rx_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (rx_samp) rx_next = ST_STOP;
      end
      ST_STOP: begin
        if (rx_samp && rx_bit == 4'(STOP_BITS - 1)) begin
          rx_next = ST_IDLE;
          rx_fire = 1'b1;
        end
      end
      default: rx_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_prev       <= 1'b1;
      rx_state      <= ST_IDLE;
      rx_os         <= '0;
      rx_bit        <= '0;
      rx_sh         <= '0;
      rx_pe         <= 1'b0;
      rx_fe         <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_next;
      rx_valid <= rx_fire;
      if (rx_state == ST_IDLE) begin
        rx_os  <= '0;
        rx_bit <= '0;
        rx_pe  <= 1'b0;
        rx_fe  <= 1'b0;
      end else if (tick) begin
        rx_os <= rx_samp ? '0 : rx_os + OW'(1);
        if (rx_samp) begin
          rx_bit <= (rx_next != rx_state) ? '0 : rx_bit + 4'd1;
          if (rx_state == ST_DATA)
            rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
          if (rx_state == ST_PARITY)
            rx_pe <= rx_s2 ^ par_bit(MAX_BITS'(rx_sh), PARITY);
          if (rx_state == ST_STOP && !rx_s2)
            rx_fe <= 1'b1;
        end
      end
      if (rx_fire) begin
        rx_data       <= rx_sh;
        rx_parity_err <= rx_pe;
        rx_frame_err  <= rx_fe | ~rx_s2;
      end
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param: scoreboard bench over four configurations
// of the UART core (8N1, 8E2 loopback, 8O1, 5N1).
module tb_uart_core_param;

  localparam int BIT = 160;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } rx_exp_t;

  logic clk;
  logic rst_n;

  logic [7:0] a_tx_data, a_rx_data;
  logic a_tx_valid, a_tx_ready, a_tx, a_tx_done;
  logic a_rx, a_rx_valid, a_rx_pe, a_rx_fe;

  logic [7:0] b_tx_data, b_rx_data;
  logic b_tx_valid, b_tx_ready, b_tx, b_tx_done;
  logic b_rx, b_rx_valid, b_rx_pe, b_rx_fe;

  logic [7:0] c_tx_data, c_rx_data;
  logic c_tx_valid, c_tx_ready, c_tx, c_tx_done;
  logic c_rx, c_rx_valid, c_rx_pe, c_rx_fe;

  logic [4:0] d_tx_data, d_rx_data;
  logic d_tx_valid, d_tx_ready, d_tx, d_tx_done;
  logic d_rx, d_rx_valid, d_rx_pe, d_rx_fe;

  int n_cmp = 0;
  int n_bad = 0;

  rx_exp_t q_a[$];
  rx_exp_t q_b[$];
  rx_exp_t q_c[$];
  rx_exp_t ea, eb, ec;

  assign b_rx = b_tx;

  uart_core_param u_a (
    .clk(clk), .rst_n(rst_n),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid),
    .tx_ready(a_tx_ready), .tx(a_tx), .tx_done(a_tx_done),
    .rx(a_rx), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
    .rx_parity_err(a_rx_pe), .rx_frame_err(a_rx_fe)
  );

  uart_core_param #(.PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid),
    .tx_ready(b_tx_ready), .tx(b_tx), .tx_done(b_tx_done),
    .rx(b_rx), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .rx_parity_err(b_rx_pe), .rx_frame_err(b_rx_fe)
  );

  uart_core_param #(.PARITY(1)) u_c (
    .clk(clk), .rst_n(rst_n),
    .tx_data(c_tx_data), .tx_valid(c_tx_valid),
    .tx_ready(c_tx_ready), .tx(c_tx), .tx_done(c_tx_done),
    .rx(c_rx), .rx_data(c_rx_data), .rx_valid(c_rx_valid),
    .rx_parity_err(c_rx_pe), .rx_frame_err(c_rx_fe)
  );

  uart_core_param #(.DATA_BITS(5)) u_d (
    .clk(clk), .rst_n(rst_n),
    .tx_data(d_tx_data), .tx_valid(d_tx_valid),
    .tx_ready(d_tx_ready), .tx(d_tx), .tx_done(d_tx_done),
    .rx(d_rx), .rx_data(d_rx_data), .rx_valid(d_rx_valid),
    .rx_parity_err(d_rx_pe), .rx_frame_err(d_rx_fe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Line level of bit idx in a frame: start, LSB-first data,
  // optional parity, then stop ones.
  function automatic logic exp_bit(
    input logic [8:0] d,
    input int         nb,
    input int         par,
    input int         idx
  );
    logic [8:0] m;
    m = d & 9'((1 << nb) - 1);
    if (idx == 0) return 1'b0;
    if (idx <= nb) return m[idx-1];
    if (par != 0 && idx == nb + 1)
      return (par == 1) ? ~^m : ^m;
    return 1'b1;
  endfunction

  function automatic int qsize(input int which);
    case (which)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic set_rx(input int which, input logic v);
    if (which == 0) a_rx = v;
    else c_rx = v;
  endtask

  task automatic drive_frame(
    input int         which,
    input logic [8:0] d,
    input int         nb,
    input int         par,
    input logic       pflip,
    input int         nstop,
    input logic       stop_low
  );
    int   n;
    int   pidx;
    int   sidx;
    logic b;
    pidx = nb + 1;
    sidx = (par != 0) ? nb + 2 : nb + 1;
    n = sidx + nstop;
    for (int i = 0; i < n; i++) begin
      b = exp_bit(d, nb, par, i);
      if (par != 0 && i == pidx) b = b ^ pflip;
      if (i == sidx && stop_low) b = 1'b0;
      set_rx(which, b);
      repeat (BIT) @(posedge clk);
    end
    set_rx(which, 1'b1);
    #1;
  endtask

  task automatic drain(input int which, input int lim);
    int n;
    n = 0;
    while (qsize(which) != 0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain", 32'(qsize(which)), 0);
  endtask

  always @(negedge clk) begin
    if (a_rx_valid) begin
      chk("a_rx_pending", 32'(q_a.size() != 0), 1);
      if (q_a.size() != 0) begin
        ea = q_a.pop_front();
        chk("a_rx_data", a_rx_data, ea.d);
        chk("a_rx_pe", a_rx_pe, ea.pe);
        chk("a_rx_fe", a_rx_fe, ea.fe);
      end
    end
    if (b_rx_valid) begin
      chk("b_rx_pending", 32'(q_b.size() != 0), 1);
      if (q_b.size() != 0) begin
        eb = q_b.pop_front();
        chk("b_rx_data", b_rx_data, eb.d);
        chk("b_rx_pe", b_rx_pe, eb.pe);
        chk("b_rx_fe", b_rx_fe, eb.fe);
      end
    end
    if (c_rx_valid) begin
      chk("c_rx_pending", 32'(q_c.size() != 0), 1);
      if (q_c.size() != 0) begin
        ec = q_c.pop_front();
        chk("c_rx_data", c_rx_data, ec.d);
        chk("c_rx_pe", c_rx_pe, ec.pe);
        chk("c_rx_fe", c_rx_fe, ec.fe);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    int n_low;
    rst_n = 1'b0;
    a_tx_data = '0; a_tx_valid = 1'b0; a_rx = 1'b1;
    b_tx_data = '0; b_tx_valid = 1'b0;
    c_tx_data = '0; c_tx_valid = 1'b0; c_rx = 1'b1;
    d_tx_data = '0; d_tx_valid = 1'b0; d_rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_a_tx", a_tx, 1);
    chk("rst_a_rdy", a_tx_ready, 0);
    chk("rst_a_done", a_tx_done, 0);
    chk("rst_a_rxv", a_rx_valid, 0);
    chk("rst_a_rxd", a_rx_data, 0);
    chk("rst_a_pe", a_rx_pe, 0);
    chk("rst_a_fe", a_rx_fe, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_a_rdy", a_tx_ready, 1);

    // 8N1 transmit of 0xA5
    a_tx_data = 8'hA5;
    a_tx_valid = 1'b1;
    @(posedge clk);
    #1;
    a_tx_valid = 1'b0;
    for (int k = 1; k <= 1601; k++) begin
      chk("t1_tx", a_tx,
          (k == 1601) ? 1'b1 : exp_bit(9'hA5, 8, 0, (k - 1) / BIT));
      chk("t1_done", a_tx_done, 32'(k == 1600));
      chk("t1_rdy", a_tx_ready, 32'(k == 1601));
      @(posedge clk);
      #1;
    end

    // 8E2 loopback of 0x3C
    q_b.push_back('{d: 9'h3C, pe: 1'b0, fe: 1'b0});
    b_tx_data = 8'h3C;
    b_tx_valid = 1'b1;
    @(posedge clk);
    #1;
    b_tx_valid = 1'b0;
    repeat (9 * BIT + 79) @(posedge clk);
    #1;
    chk("t2_par_bit", b_tx, exp_bit(9'h3C, 8, 2, 9));
    drain(1, 3000);

    // 8O1 receive: good parity, bad parity, low stop bit
    q_c.push_back('{d: 9'h01, pe: 1'b0, fe: 1'b0});
    drive_frame(2, 9'h01, 8, 1, 1'b0, 1, 1'b0);
    repeat (20) @(posedge clk);
    q_c.push_back('{d: 9'h01, pe: 1'b1, fe: 1'b0});
    drive_frame(2, 9'h01, 8, 1, 1'b1, 1, 1'b0);
    repeat (20) @(posedge clk);
    q_c.push_back('{d: 9'h55, pe: 1'b0, fe: 1'b1});
    drive_frame(2, 9'h55, 8, 1, 1'b0, 1, 1'b1);
    drain(2, 2000);

    // glitch shorter than half a bit, then a real frame
    a_rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    a_rx = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    chk("t4_no_rx", 32'(q_a.size()), 0);
    q_a.push_back('{d: 9'h5A, pe: 1'b0, fe: 1'b0});
    drive_frame(0, 9'h5A, 8, 0, 1'b0, 1, 1'b0);
    drain(0, 2000);

    // 5N1 back-to-back with tx_valid held
    d_tx_data = 5'h1F;
    d_tx_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 2242; k++) begin
      if (k == 1121 || k == 2242)
        chk("t5_tx", d_tx, 1);
      else if (k < 1121)
        chk("t5_tx", d_tx, exp_bit(9'h1F, 5, 0, (k - 1) / BIT));
      else
        chk("t5_tx", d_tx, exp_bit(9'h0A, 5, 0, (k - 1122) / BIT));
      chk("t5_done", d_tx_done, 32'(k == 1120 || k == 2241));
      chk("t5_rdy", d_tx_ready, 32'(k == 1121 || k == 2242));
      if (k == 1) d_tx_data = 5'h0A;
      if (k == 1122) d_tx_valid = 1'b0;
      @(posedge clk);
      #1;
    end

    // reset in the middle of TX and RX frames
    a_tx_data = 8'hC3;
    a_tx_valid = 1'b1;
    a_rx = 1'b0;
    @(posedge clk);
    #1;
    a_tx_valid = 1'b0;
    repeat (600) @(posedge clk);
    #1;
    rst_n = 1'b0;
    a_rx = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_tx", a_tx, 1);
    chk("t6_rdy", a_tx_ready, 0);
    chk("t6_done", a_tx_done, 0);
    chk("t6_rxv", a_rx_valid, 0);
    chk("t6_rxd", a_rx_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rel_rdy", a_tx_ready, 1);
    n_done = 0;
    n_low = 0;
    for (int k = 0; k < 2000; k++) begin
      if (a_tx_done) n_done++;
      if (!a_tx) n_low++;
      @(posedge clk);
      #1;
    end
    chk("t6_no_done", n_done, 0);
    chk("t6_tx_idle", n_low, 0);
    chk("t6_q_a", 32'(q_a.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
